// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester and memory pin bundle for the data memory arbiter
interface data_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  busy;
  logic                  grant;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output ack0, ack1, rdata0, rdata1, mem_address, mem_read, mem_write,
           mem_write_data, busy, grant
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  ack0, ack1, rdata0, rdata1, mem_address, mem_read, mem_write,
           mem_write_data, busy, grant
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin sequencer for the single-port data memory
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  grant_q, grant_d;
  logic                  op_we_q, op_we_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;

  // last_q resets to 1 so that port 0 wins the very first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      op_we_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      op_we_q  <= op_we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    logic win;
    win      = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    op_we_d  = op_we_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // on contention the port that did not win last time goes next
          if (bus.req0 && bus.req1) win = ~last_q;
          else                      win = bus.req1;
          last_d  = win;
          grant_d = win;
          op_we_d = win ? bus.we1 : bus.we0;
          addr_d  = win ? bus.addr1 : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
          wr_d    = op_we_d;
          rd_d    = ~op_we_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // memory output is registered, so read data is valid one cycle after the strobe
        if (!op_we_q) begin
          if (grant_q) rdata1_d = bus.mem_read_data;
          else         rdata0_d = bus.mem_read_data;
        end
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.busy           = busy_q;
  assign bus.grant          = grant_q;

endmodule
